signal_debouncer: RTL and testbench
===================================

SIGNAL_DEBOUNCER -- requirements
Module: signal_debouncer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops on SIGNAL_IN (legal range 2..4).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, SHALL set the consecutive enabled cycles a new level must persist before SIGNAL_OUT changes (legal range 1..2^CNT_WIDTH-1).
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set the debounce counter width.
REQ-004 CLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 RESET  input  1  SHALL be asynchronous and active-high, clearing all state immediately when asserted.
REQ-006 ENABLE  input  1  SHALL gate the debounce counter, FSM and GLITCH_COUNT; the synchronizer runs regardless.
REQ-007 SIGNAL_IN  input  1  SHALL be the raw, asynchronous, bouncing input (switch, button, external pin).
REQ-008 SIGNAL_OUT  output  1  SHALL be the debounced, clock-synchronous level; it is the SIGNAL input of the downstream edge detector.
REQ-009 BUSY  output  1  SHALL be high while the FSM is in COUNT.
REQ-010 GLITCH_COUNT  output  8  SHALL count rejected transitions (aborted COUNT periods).

Function
REQ-011 SIGNAL_IN SHALL pass through a SYNC_STAGES-deep flop chain; sync_q is the last stage; no logic SHALL use SIGNAL_IN before the chain.
REQ-012 The FSM SHALL have two states: IDLE (sync_q == SIGNAL_OUT, counter 0) and COUNT (a candidate new level is being qualified).
REQ-013 IDLE -> COUNT SHALL occur on an enabled edge where sync_q != SIGNAL_OUT, with counter loaded to 1; if DEBOUNCE_CYCLES == 1, SIGNAL_OUT SHALL instead toggle on that edge and the FSM stays IDLE.
REQ-014 In COUNT, each enabled edge with sync_q != SIGNAL_OUT SHALL increment the counter; the edge on which the count would reach DEBOUNCE_CYCLES SHALL toggle SIGNAL_OUT, clear the counter and return to IDLE.
REQ-015 In COUNT, an enabled edge with sync_q == SIGNAL_OUT SHALL abort: counter cleared, FSM to IDLE, SIGNAL_OUT unchanged, GLITCH_COUNT incremented.
REQ-016 GLITCH_COUNT SHALL saturate at 255 and never wrap.
REQ-017 The counter SHALL never exceed DEBOUNCE_CYCLES and SHALL never wrap.
REQ-018 With ENABLE low, FSM, counter, SIGNAL_OUT and GLITCH_COUNT SHALL hold; on ENABLE re-assertion, qualification resumes from the held count against the current sync_q.
REQ-019 Latency: a clean level change on SIGNAL_IN set up before edge 1, with ENABLE high, SHALL appear on SIGNAL_OUT after edge SYNC_STAGES + DEBOUNCE_CYCLES.
REQ-020 SIGNAL_OUT SHALL change at most once per clock and SHALL be driven directly from a flop (glitch-free).
REQ-021 BUSY SHALL be a registered decode of the FSM state, asserted in the cycle after IDLE -> COUNT and deasserted in the cycle after the toggle or abort.

Reset
REQ-022 RESET assertion SHALL asynchronously clear all synchronizer flops, the counter, SIGNAL_OUT, BUSY and GLITCH_COUNT to 0, and force the FSM to IDLE.
REQ-023 RESET asserted mid-COUNT SHALL discard the qualification in progress without incrementing GLITCH_COUNT.
REQ-024 After RESET deassertion, a SIGNAL_IN held high SHALL be qualified as a normal 0 -> 1 transition (REQ-019 latency).

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless stated)
REQ-025 Clean rise: SIGNAL_IN 0->1 before edge 1, held -> SIGNAL_OUT 1 after edge 6, BUSY high from edge 3 through edge 6, GLITCH_COUNT 0.
REQ-026 Bounce: SIGNAL_IN high for 2 cycles, low for 1, then held high -> one abort, GLITCH_COUNT=1, single SIGNAL_OUT rise, no intermediate toggles.
REQ-027 ENABLE gating: SIGNAL_IN rises, ENABLE dropped for 5 cycles after edge 4 -> SIGNAL_OUT rise delayed exactly 5 cycles versus REQ-025, counter held throughout.
REQ-028 Reset mid-operation: RESET pulsed between clock edges at edge 4 of a qualification -> all outputs 0 immediately, GLITCH_COUNT 0, requalification follows REQ-024.
REQ-029 Saturation and minimum: 300 single-cycle glitches -> GLITCH_COUNT stops at 255; with DEBOUNCE_CYCLES=1, a clean rise -> SIGNAL_OUT 1 after edge 3, BUSY never asserted.

Source files
------------

// File: rtl/signal_debouncer.sv
// rtl/signal_debouncer.sv - synchronizer plus counter-qualified debounce FSM with glitch statistics
module signal_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       signal_in_i,
  output logic       signal_out_o,
  output logic       busy_o,
  output logic [7:0] glitch_count_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_TARGET = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_chain_q;
  logic                   sync_q;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic [7:0]             glitch_q, glitch_d;
  logic                   busy_q, busy_d;

  logic                   differs;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic                   hit;

  // Metastability chain: runs every cycle, independent of enable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_chain_q <= '0;
    end else begin
      sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], signal_in_i};
    end
  end

  assign sync_q  = sync_chain_q[SYNC_STAGES-1];
  assign differs = sync_q ^ out_q;
  // In IDLE the counter is 0, so cnt_inc == 1 and hit covers the single-cycle case.
  assign cnt_inc = cnt_q + CNT_ONE;
  assign hit     = (cnt_inc == CNT_TARGET);

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: leave IDLE on a differing level unless it qualifies immediately.
  always_comb begin
    state_d = state_q;
    if (enable_i) begin
      case (state_q)
        ST_IDLE: begin
          if (differs && !hit) begin
            state_d = ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (!differs || hit) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs/datapath: count qualification, toggle on target, tally aborts.
  always_comb begin
    cnt_d    = cnt_q;
    out_d    = out_q;
    glitch_d = glitch_q;
    if (enable_i) begin
      case (state_q)
        ST_IDLE: begin
          if (differs) begin
            if (hit) begin
              out_d = ~out_q;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        ST_COUNT: begin
          if (!differs) begin
            cnt_d = '0;
            if (glitch_q != 8'hFF) begin
              glitch_d = glitch_q + 8'd1;
            end
          end else if (hit) begin
            out_d = ~out_q;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: cnt_d = '0;
      endcase
    end
    busy_d = (state_d == ST_COUNT);
  end

  // Datapath registers; signal_out and busy come straight from flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      out_q    <= 1'b0;
      glitch_q <= 8'd0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      glitch_q <= glitch_d;
      busy_q   <= busy_d;
    end
  end

  assign signal_out_o   = out_q;
  assign busy_o         = busy_q;
  assign glitch_count_o = glitch_q;

endmodule

// File: tb/tb_signal_debouncer.sv
// tb/tb_signal_debouncer.sv - randomized and directed checks of signal_debouncer against a behavioural model
module tb_signal_debouncer;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       sig;
  logic       out4, busy4, out1, busy1;
  logic [7:0] gc4, gc1;

  int tests = 0;
  int fails = 0;

  signal_debouncer #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(16)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .signal_in_i(sig),
    .signal_out_o(out4), .busy_o(busy4), .glitch_count_o(gc4)
  );

  signal_debouncer #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(16)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .signal_in_i(sig),
    .signal_out_o(out1), .busy_o(busy1), .glitch_count_o(gc1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model: the FSM sees the input from S edges ago; a new level
  // must be seen on D consecutive enabled edges, an early return is a glitch.
  bit hist[$];
  int dcyc[2] = '{4, 1};
  int run[2];
  int mout[2];
  int mglitch[2];

  task automatic model_reset();
    hist = {};
    repeat (S) hist.push_back(1'b0);
    for (int i = 0; i < 2; i++) begin
      run[i] = 0; mout[i] = 0; mglitch[i] = 0;
    end
  endtask

  task automatic model_edge(input bit in_v, input bit en_v);
    bit s;
    s = hist.pop_front();
    hist.push_back(in_v);
    if (en_v) begin
      for (int i = 0; i < 2; i++) begin
        if (int'(s) != mout[i]) begin
          run[i] = run[i] + 1;
          if (run[i] == dcyc[i]) begin
            mout[i] = 1 - mout[i];
            run[i]  = 0;
          end
        end else if (run[i] > 0) begin
          if (mglitch[i] < 255) mglitch[i] = mglitch[i] + 1;
          run[i] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    bit iv, ev;
    iv = sig;
    ev = enable;
    @(posedge clk);
    model_edge(iv, ev);
    #1;
    check("out4",    32'(out4),  32'(mout[0]));
    check("busy4",   32'(busy4), 32'(run[0] > 0));
    check("glitch4", 32'(gc4),   32'(mglitch[0]));
    check("out1",    32'(out1),  32'(mout[1]));
    check("busy1",   32'(busy1), 32'(run[1] > 0));
    check("glitch1", 32'(gc1),   32'(mglitch[1]));
  endtask

  // Asynchronous pulse placed between clock edges.
  task automatic pulse_reset(input bit check_now);
    #3;
    rst = 1'b1;
    #1;
    if (check_now) begin
      check("rst_out4",  32'(out4),  0);
      check("rst_busy4", 32'(busy4), 0);
      check("rst_gc4",   32'(gc4),   0);
      check("rst_out1",  32'(out1),  0);
    end
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  int first4, first1, busy_mask, busy1_seen, toggles;
  logic prev4;

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    sig    = 1'b0;
    model_reset();
    #2;
    check("init_out4",   32'(out4),  0);
    check("init_busy4",  32'(busy4), 0);
    check("init_gc4",    32'(gc4),   0);
    #10;
    rst    = 1'b0;
    enable = 1'b1;
    @(posedge clk);
    #1;

    // Clean rise: output after edge 6 (DEB=4) and edge 3 (DEB=1).
    pulse_reset(1'b0);
    sig = 1'b1;
    first4 = 0; first1 = 0; busy_mask = 0; busy1_seen = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (out4 && first4 == 0) first4 = e;
      if (out1 && first1 == 0) first1 = e;
      if (busy4) busy_mask |= (1 << e);
      if (busy1) busy1_seen = 1;
    end
    check("rise_edge", first4, 6);
    check("busy_window", busy_mask, 32'h38);
    check("rise_gc", 32'(gc4), 0);
    check("min_rise_edge", first1, 3);
    check("min_busy_never", busy1_seen, 0);

    // Bounce: high 2, low 1, then held high.
    pulse_reset(1'b0);
    sig = 1'b1;
    toggles = 0; prev4 = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 2) sig = 1'b0;
      if (e == 3) sig = 1'b1;
      if (out4 != prev4) toggles++;
      prev4 = out4;
    end
    check("bounce_gc", 32'(gc4), 1);
    check("bounce_toggles", toggles, 1);
    check("bounce_level", 32'(out4), 1);

    // Enable dropped for 5 cycles after edge 4: rise moves to edge 11.
    pulse_reset(1'b0);
    sig = 1'b1;
    first4 = 0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 4) enable = 1'b0;
      if (e == 9) enable = 1'b1;
      if (out4 && first4 == 0) first4 = e;
      if (e == 9) check("gated_busy_held", 32'(busy4), 1);
    end
    check("gated_rise_edge", first4, 11);

    // Reset mid-qualification, input held high: requalified from scratch.
    pulse_reset(1'b0);
    sig = 1'b1;
    repeat (4) tick();
    check("pre_rst_busy", 32'(busy4), 1);
    pulse_reset(1'b1);
    first4 = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (out4 && first4 == 0) first4 = e;
    end
    check("requal_edge", first4, 6);
    check("requal_gc", 32'(gc4), 0);

    // 300 single-cycle glitches saturate the counter at 255.
    pulse_reset(1'b0);
    for (int k = 0; k < 300; k++) begin
      sig = 1'b1;
      tick();
      sig = 1'b0;
      tick();
    end
    repeat (4) tick();
    check("sat_gc", 32'(gc4), 255);
    check("sat_level", 32'(out4), 0);

    // Randomized segments of levels with occasional enable drops.
    pulse_reset(1'b0);
    for (int seg = 0; seg < 400; seg++) begin
      int len;
      sig = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int c = 0; c < len; c++) begin
        enable = ($urandom_range(0, 7) != 0);
        tick();
      end
    end
    enable = 1'b1;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
